aes_iter_core: RTL and testbench



---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_round_unit.sv | 75 +++++++
 rtl/aes_iter_core.sv | 147 ++++++++++++++
 tb/tb_aes_iter_core.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES tables, GF(2^8) helpers and common types for the iterative AES core.
package aes_pkg;

    typedef logic [127:0]      state_t;
    typedef logic [31:0]       word_t;
    typedef logic [0:255][7:0] sbox_t;

    localparam sbox_t SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // The inverse table is derived from the forward one at elaboration time.
    function automatic sbox_t gen_inv_sbox();
        sbox_t inv;
        inv = '0;
        for (int i = 0; i < 256; i++) inv[SBOX[i]] = 8'(i);
        return inv;
    endfunction

    localparam sbox_t INV_SBOX = gen_inv_sbox();

    localparam logic [0:15][7:0] RCON = {
        8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t sub_word(input word_t x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic state_t add_round_key(input state_t s, input state_t rk);
        return s ^ rk;
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational single AES round: forward cipher round or straight inverse-cipher round.
module aes_round_unit
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   decrypt,
    input  logic   last_round,
    output state_t next_state
);

    typedef logic [0:15][7:0] bytes_t;
    typedef logic [0:3][3:0]  coef_t;

    localparam coef_t MIX_FWD = {4'h2, 4'h3, 4'h1, 4'h1};
    localparam coef_t MIX_INV = {4'he, 4'hb, 4'hd, 4'h9};

    function automatic bytes_t sub_bytes(input bytes_t s);
        bytes_t r;
        for (int i = 0; i < 16; i++) r[i] = SBOX[s[i]];
        return r;
    endfunction

    function automatic bytes_t inv_sub_bytes(input bytes_t s);
        bytes_t r;
        for (int i = 0; i < 16; i++) r[i] = INV_SBOX[s[i]];
        return r;
    endfunction

    // Byte 4*c+row holds row 'row' of column 'c'.
    function automatic bytes_t shift_rows(input bytes_t s);
        bytes_t r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[4*c+row] = s[4*((c+row)%4)+row];
        return r;
    endfunction

    function automatic bytes_t inv_shift_rows(input bytes_t s);
        bytes_t r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[4*c+row] = s[4*((c+4-row)%4)+row];
        return r;
    endfunction

    // Circulant matrix: each output row uses the coefficient vector rotated by its row index.
    function automatic bytes_t mix_columns(input bytes_t s, input coef_t coef);
        bytes_t r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                r[4*c+row] = 8'h00;
                for (int k = 0; k < 4; k++)
                    r[4*c+row] = r[4*c+row] ^ gmul(s[4*c+k], coef[(k-row+4)%4]);
            end
        return r;
    endfunction

    bytes_t work;

    always_comb begin
        work = state;
        if (!decrypt) begin
            work = shift_rows(sub_bytes(work));
            if (!last_round) work = mix_columns(work, MIX_FWD);
            work = add_round_key(work, round_key);
        end else begin
            work = inv_sub_bytes(inv_shift_rows(work));
            work = add_round_key(work, round_key);
            if (!last_round) work = mix_columns(work, MIX_INV);
        end
        next_state = work;
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative round-per-cycle AES engine (AES-128/192/256 by NK) with sequential key
// expansion into an internal round-key store and valid/ready key, input and output channels.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [NK*32-1:0] key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             keys_loaded
);

    localparam int NR = nr_of(NK);
    localparam int NW = 4 * (NR + 1);
    localparam int WW = $clog2(NW);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_iter_core: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} fsm_t;

    fsm_t            fsm;
    word_t [0:NW-1]  w;
    logic [WW-1:0]   wcnt;
    logic [2:0]      phase;
    logic [3:0]      rcon_idx;
    logic [3:0]      round;
    logic            decrypt_q;
    state_t          state_q;

    word_t           prev_word;
    word_t           temp_word;
    word_t           new_word;
    state_t          rk_load;
    state_t          rk_round;
    state_t          round_out;
    logic            key_fire;

    function automatic state_t rk_at(input logic [3:0] idx);
        logic [WW-1:0] b;
        b = WW'({idx, 2'b00});
        return {w[b], w[b + WW'(1)], w[b + WW'(2)], w[b + WW'(3)]};
    endfunction

    assign key_ready = (fsm == IDLE);
    assign in_ready  = (fsm == IDLE) && keys_loaded && !key_valid;
    assign key_fire  = (fsm == IDLE) && key_valid;

    // phase tracks i mod NK, so no divider is needed for the Rcon/SubWord decisions.
    always_comb begin
        prev_word = w[wcnt - WW'(1)];
        temp_word = prev_word;
        if (phase == 3'd0)
            temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {RCON[rcon_idx], 24'h0};
        else if (NK == 8 && phase == 3'd4)
            temp_word = sub_word(prev_word);
        new_word = w[wcnt - WW'(NK)] ^ temp_word;
    end

    always_comb begin
        rk_load  = rk_at(in_decrypt ? 4'(NR) : 4'd0);
        rk_round = rk_at(decrypt_q ? 4'(NR) - round : round);
    end

    aes_round_unit u_round (
        .state      (state_q),
        .round_key  (rk_round),
        .decrypt    (decrypt_q),
        .last_round (round == 4'(NR)),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (key_fire)
            w[0:NK-1] <= key;
        else if (fsm == EXPAND)
            w[wcnt] <= new_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= IDLE;
            keys_loaded <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            round       <= '0;
            state_q     <= '0;
            decrypt_q   <= 1'b0;
            wcnt        <= '0;
            phase       <= '0;
            rcon_idx    <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (key_valid) begin
                        keys_loaded <= 1'b0;
                        wcnt        <= WW'(NK);
                        phase       <= '0;
                        rcon_idx    <= 4'd1;
                        fsm         <= EXPAND;
                    end else if (in_valid && keys_loaded) begin
                        state_q   <= add_round_key(in_data, rk_load);
                        decrypt_q <= in_decrypt;
                        round     <= 4'd1;
                        fsm       <= ROUND;
                    end
                end
                EXPAND: begin
                    wcnt  <= wcnt + WW'(1);
                    phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0) rcon_idx <= rcon_idx + 4'd1;
                    if (wcnt == WW'(NW - 1)) begin
                        keys_loaded <= 1'b1;
                        fsm         <= IDLE;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    round   <= round + 4'd1;
                    if (round == 4'(NR)) begin
                        out_data  <= round_out;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 bench for aes_iter_core at NK=4, 6 and 8, one selected instance at a time.
module tb_aes_iter_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   sel = 2'd0;
    logic [255:0] key_all = '0;
    logic         key_valid = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_decrypt = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;

    logic [2:0]   key_ready_v, in_ready_v, out_valid_v, keys_loaded_v;
    logic [127:0] out_data_v [3];

    logic         key_ready_o, in_ready_o, out_valid_o, keys_loaded_o;
    logic [127:0] out_data_o;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K2   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes_iter_core #(.NK(4)) u_aes128 (
        .clk(clk), .rst(rst),
        .key_valid(key_valid && sel == 2'd0), .key_ready(key_ready_v[0]), .key(key_all[255:128]),
        .in_valid(in_valid && sel == 2'd0), .in_ready(in_ready_v[0]), .in_decrypt(in_decrypt),
        .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready && sel == 2'd0),
        .out_data(out_data_v[0]), .keys_loaded(keys_loaded_v[0])
    );

    aes_iter_core #(.NK(6)) u_aes192 (
        .clk(clk), .rst(rst),
        .key_valid(key_valid && sel == 2'd1), .key_ready(key_ready_v[1]), .key(key_all[255:64]),
        .in_valid(in_valid && sel == 2'd1), .in_ready(in_ready_v[1]), .in_decrypt(in_decrypt),
        .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready && sel == 2'd1),
        .out_data(out_data_v[1]), .keys_loaded(keys_loaded_v[1])
    );

    aes_iter_core #(.NK(8)) u_aes256 (
        .clk(clk), .rst(rst),
        .key_valid(key_valid && sel == 2'd2), .key_ready(key_ready_v[2]), .key(key_all),
        .in_valid(in_valid && sel == 2'd2), .in_ready(in_ready_v[2]), .in_decrypt(in_decrypt),
        .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready && sel == 2'd2),
        .out_data(out_data_v[2]), .keys_loaded(keys_loaded_v[2])
    );

    always_comb begin
        key_ready_o   = key_ready_v[0];
        in_ready_o    = in_ready_v[0];
        out_valid_o   = out_valid_v[0];
        keys_loaded_o = keys_loaded_v[0];
        out_data_o    = out_data_v[0];
        case (sel)
            2'd1: begin
                key_ready_o = key_ready_v[1]; in_ready_o = in_ready_v[1];
                out_valid_o = out_valid_v[1]; keys_loaded_o = keys_loaded_v[1];
                out_data_o = out_data_v[1];
            end
            2'd2: begin
                key_ready_o = key_ready_v[2]; in_ready_o = in_ready_v[2];
                out_valid_o = out_valid_v[2]; keys_loaded_o = keys_loaded_v[2];
                out_data_o = out_data_v[2];
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a key, returns cycles from accept edge until keys_loaded (-1 on timeout).
    task automatic send_key(input logic [255:0] k, output int cycles);
        int n;
        key_all = k;
        key_valid = 1'b1;
        n = 0;
        #1;
        while (!key_ready_o && n < 100) begin tick(); n++; end
        tick();
        key_valid = 1'b0;
        cycles = 0;
        while (!keys_loaded_o && cycles < 200) begin tick(); cycles++; end
        if (!keys_loaded_o) cycles = -1;
    endtask

    // Sends one block, returns latency from accept edge to out_valid and the result.
    task automatic run_block(input logic [127:0] d, input logic dec, output int lat,
                             output logic [127:0] res);
        int n;
        in_data = d;
        in_decrypt = dec;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready_o && n < 200) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 100) begin tick(); lat++; end
        if (!out_valid_o) lat = -1;
        res = out_data_o;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            n_cmp++;
            if (keys_loaded_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got kl=%b ov=%b od=%h, required 0/0/0", s,
                         keys_loaded_o, out_valid_o, out_data_o);
            end
            n_cmp++;
            if (key_ready_o !== 1'b1 || in_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready[%0d]: got key_ready=%b in_ready=%b, required 1/0", s,
                         key_ready_o, in_ready_o);
            end
        end
        sel = 2'd0;
    endtask

    task automatic test_aes128();
        int cyc, lat;
        logic [127:0] res;
        sel = 2'd0;
        send_key(K128, cyc);
        n_cmp++;
        if (cyc !== 40) begin n_fail++; $display("FAIL expand128_cycles: got %0d required 40", cyc); end
        run_block(PT, 1'b0, lat, res);
        n_cmp++;
        if (lat !== 10) begin n_fail++; $display("FAIL enc128_latency: got %0d required 10", lat); end
        n_cmp++;
        if (res !== CT1) begin n_fail++; $display("FAIL enc128_data: got %h required %h", res, CT1); end
        n_cmp++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL enc128_out_drop: got %b required 0", out_valid_o); end
        run_block(CT1, 1'b1, lat, res);
        n_cmp++;
        if (lat !== 10) begin n_fail++; $display("FAIL dec128_latency: got %0d required 10", lat); end
        n_cmp++;
        if (res !== PT) begin n_fail++; $display("FAIL dec128_data: got %h required %h", res, PT); end
        send_key(K2, cyc);
        run_block(PT2, 1'b0, lat, res);
        n_cmp++;
        if (res !== CT2) begin n_fail++; $display("FAIL enc128_key2: got %h required %h", res, CT2); end
        run_block(CT2, 1'b1, lat, res);
        n_cmp++;
        if (res !== PT2) begin n_fail++; $display("FAIL dec128_key2: got %h required %h", res, PT2); end
    endtask

    task automatic test_aes192();
        int cyc, lat;
        logic [127:0] res;
        sel = 2'd1;
        send_key(K192, cyc);
        n_cmp++;
        if (cyc !== 46) begin n_fail++; $display("FAIL expand192_cycles: got %0d required 46", cyc); end
        run_block(PT, 1'b0, lat, res);
        n_cmp++;
        if (lat !== 12) begin n_fail++; $display("FAIL enc192_latency: got %0d required 12", lat); end
        n_cmp++;
        if (res !== CT6) begin n_fail++; $display("FAIL enc192_data: got %h required %h", res, CT6); end
        run_block(CT6, 1'b1, lat, res);
        n_cmp++;
        if (res !== PT) begin n_fail++; $display("FAIL dec192_data: got %h required %h", res, PT); end
    endtask

    task automatic test_aes256();
        int cyc, lat;
        logic [127:0] res;
        sel = 2'd2;
        send_key(K256, cyc);
        n_cmp++;
        if (cyc !== 52) begin n_fail++; $display("FAIL expand256_cycles: got %0d required 52", cyc); end
        run_block(PT, 1'b0, lat, res);
        n_cmp++;
        if (lat !== 14) begin n_fail++; $display("FAIL enc256_latency: got %0d required 14", lat); end
        n_cmp++;
        if (res !== CT8) begin n_fail++; $display("FAIL enc256_data: got %h required %h", res, CT8); end
        run_block(CT8, 1'b1, lat, res);
        n_cmp++;
        if (res !== PT) begin n_fail++; $display("FAIL dec256_data: got %h required %h", res, PT); end
        sel = 2'd0;
    endtask

    task automatic test_backpressure();
        int n, bad;
        sel = 2'd0;
        in_data = PT2;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready_o && n < 200) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_o && n < 100) begin tick(); n++; end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o !== 1'b1 || out_data_o !== CT2 || in_ready_o !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bad cycles, last od=%h ov=%b ir=%b, required %h/1/0",
                     bad, out_data_o, out_valid_o, in_ready_o, CT2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: got ov=%b ir=%b, required 0/1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, cyc;
        logic [127:0] r1, r2;
        sel = 2'd0;
        in_data = PT2;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        first = -1;
        second = -1;
        r1 = '0;
        r2 = '0;
        cyc = 0;
        while (second < 0 && cyc < 100) begin
            tick();
            cyc++;
            if (out_valid_o) begin
                if (first < 0) begin first = cyc; r1 = out_data_o; end
                else begin second = cyc; r2 = out_data_o; in_valid = 1'b0; end
            end
        end
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (second - first !== 12) begin
            n_fail++;
            $display("FAIL back_to_back_interval: got %0d required 12", second - first);
        end
        n_cmp++;
        if (r1 !== CT2 || r2 !== CT2) begin
            n_fail++;
            $display("FAIL back_to_back_data: got %h %h required %h", r1, r2, CT2);
        end
    endtask

    task automatic test_key_priority();
        int n, lat;
        sel = 2'd0;
        key_all = K128;
        key_valid = 1'b1;
        in_data = PT;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_o !== 1'b0 || key_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_ready: got in_ready=%b key_ready=%b, required 0/1", in_ready_o, key_ready_o);
        end
        tick();
        key_valid = 1'b0;
        n_cmp++;
        if (keys_loaded_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_key_taken: got keys_loaded=%b required 0", keys_loaded_o);
        end
        n = 0;
        while (!in_ready_o && n < 200) begin tick(); n++; end
        n_cmp++;
        if (n !== 40) begin n_fail++; $display("FAIL prio_block_wait: got %0d required 40", n); end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 100) begin tick(); lat++; end
        n_cmp++;
        if (out_data_o !== CT1 || lat !== 10) begin
            n_fail++;
            $display("FAIL prio_new_key_data: got %h lat %0d required %h lat 10", out_data_o, lat, CT1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        int n, cyc, lat;
        logic [127:0] res;
        sel = 2'd0;
        in_data = PT;
        in_decrypt = 1'b0;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready_o && n < 200) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b0 || out_data_o !== 128'h0 || keys_loaded_o !== 1'b0 || key_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_round5: got ov=%b od=%h kl=%b kr=%b, required 0/0/0/1",
                     out_valid_o, out_data_o, keys_loaded_o, key_ready_o);
        end
        rst = 1'b0;
        tick();
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid_o !== 1'b0) n++;
            tick();
        end
        n_cmp++;
        if (n !== 0) begin n_fail++; $display("FAIL rst_round5_no_output: %0d cycles with out_valid, required 0", n); end
        key_all = K2;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (keys_loaded_o !== 1'b0 || key_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_expand: got kl=%b kr=%b ov=%b, required 0/1/0", keys_loaded_o, key_ready_o, out_valid_o);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 30; i++) tick();
        n_cmp++;
        if (keys_loaded_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_expand_abandoned: got keys_loaded=%b required 0", keys_loaded_o);
        end
        send_key(K2, cyc);
        n_cmp++;
        if (cyc !== 40) begin n_fail++; $display("FAIL rst_rekey_cycles: got %0d required 40", cyc); end
        run_block(PT2, 1'b0, lat, res);
        n_cmp++;
        if (res !== CT2 || lat !== 10) begin
            n_fail++;
            $display("FAIL rst_recover_data: got %h lat %0d required %h lat 10", res, lat, CT2);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_back_to_back();
        test_key_priority();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
